// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered sync, DE and SOL/SOF flags.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN; otherwise FRAME is tied to 0.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       HS,
    output logic       VS,
    output logic       DE,
    output logic       SOL,
    output logic       SOF,
    output logic [7:0] FRAME
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       de_q, de_d;
    logic       sol_q, sol_d;
    logic       sof_q, sof_d;

    // Flags are decoded from the next counter values so they land in the same cycle as X/Y.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        sol_d = 1'b0;
        sof_d = 1'b0;
        if (CE) begin
            if (h_q == H_LAST) begin
                h_d   = '0;
                sol_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d   = '0;
                    sof_d = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        hs_d = (({1'b0, h_d} >= HS_FIRST) && ({1'b0, h_d} <= HS_LAST)) ? HS_POL : ~HS_POL;
        vs_d = (({1'b0, v_d} >= VS_FIRST) && ({1'b0, v_d} <= VS_LAST)) ? VS_POL : ~VS_POL;
        de_d = ({1'b0, h_d} < H_VIS) && ({1'b0, v_d} < V_VIS);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_q   <= H_LAST;
            v_q   <= V_LAST;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            sol_q <= 1'b0;
            sof_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            sol_q <= sol_d;
            sof_q <= sof_d;
        end
    end

    assign X   = h_q;
    assign Y   = v_q;
    assign HS  = hs_q;
    assign VS  = vs_q;
    assign DE  = de_q;
    assign SOL = sol_q;
    assign SOF = sof_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_q, frame_d;

    // Resets to 255 so the first frame after reset reads 0.
    always_comb begin
        frame_d = frame_q;
        if (sof_d) begin
            frame_d = frame_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_q <= '1;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign FRAME = frame_q;
`else
    assign FRAME = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default-geometry DUT for reset/line checks,
// small-geometry DUT (positive polarities) for frame, mid-frame reset and frame counter checks.
module tb_vga_timing;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_hs, a_vs, a_de, a_sol, a_sof;
    logic       b_hs, b_vs, b_de, b_sol, b_sof;
    logic [7:0] a_frame, b_frame;

    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam int unsigned FR_RST  = 255;
    localparam bit          FR_CNT  = 1'b1;
`else
    localparam int unsigned FR_RST  = 0;
    localparam bit          FR_CNT  = 1'b0;
`endif

    vga_timing u_a (
        .CLK(clk), .RST(rst), .CE(ce),
        .X(a_x), .Y(a_y), .HS(a_hs), .VS(a_vs), .DE(a_de),
        .SOL(a_sol), .SOF(a_sof), .FRAME(a_frame)
    );

    // 16 x 10 raster: HS at X=10..12, VS at Y=7..8, active 8 x 6.
    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_b (
        .CLK(clk), .RST(rst), .CE(ce),
        .X(b_x), .Y(b_y), .HS(b_hs), .VS(b_vs), .DE(b_de),
        .SOL(b_sol), .SOF(b_sof), .FRAME(b_frame)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic        ce;
        int unsigned x;
        int unsigned y;
        logic        hs;
        logic        vs;
        logic        de;
        logic        sol;
        logic        sof;
        int unsigned frame;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=%0d req=%0d", name, act, req);
        end
    endtask

    task automatic step(input logic r, input logic c);
        @(negedge clk);
        rst = r;
        ce  = c;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int unsigned hs_cnt, de_cnt, sol_cnt, sof_cnt, vs_cnt, de_late;
        int unsigned hs_min, hs_max, de_max, vs_min, vs_max, x_prev, x_exp, k;
        logic        c;
        bit          found;

        vecs[0] = '{1'b1, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FR_RST};
        vecs[1] = '{1'b1, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FR_RST};
        vecs[2] = '{1'b1, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FR_RST};
        vecs[3] = '{1'b0, 1'b0, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FR_RST};
        vecs[4] = '{1'b0, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        vecs[5] = '{1'b0, 1'b0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b0, 1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[7] = '{1'b0, 1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[8] = '{1'b0, 1'b1,   2,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].ce);
            check($sformatf("vec%0d_x", i),     a_x,     vecs[i].x);
            check($sformatf("vec%0d_y", i),     a_y,     vecs[i].y);
            check($sformatf("vec%0d_hs", i),    a_hs,    vecs[i].hs);
            check($sformatf("vec%0d_vs", i),    a_vs,    vecs[i].vs);
            check($sformatf("vec%0d_de", i),    a_de,    vecs[i].de);
            check($sformatf("vec%0d_sol", i),   a_sol,   vecs[i].sol);
            check($sformatf("vec%0d_sof", i),   a_sof,   vecs[i].sof);
            check($sformatf("vec%0d_frame", i), a_frame, vecs[i].frame);
        end

        // One full line at full rate, starting from X=2, Y=0.
        hs_cnt = 0; de_cnt = 0; sol_cnt = 0; sof_cnt = 0;
        hs_min = 1023; hs_max = 0; de_max = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b1);
            if (a_hs == 1'b0) begin
                hs_cnt++;
                if (a_x < hs_min) hs_min = a_x;
                if (a_x > hs_max) hs_max = a_x;
            end
            if (a_de) begin
                de_cnt++;
                if (a_x > de_max) de_max = a_x;
            end
            if (a_sol) sol_cnt++;
            if (a_sof) sof_cnt++;
        end
        check("line_hs_cnt", hs_cnt, 96);
        check("line_hs_min", hs_min, 656);
        check("line_hs_max", hs_max, 751);
        check("line_de_cnt", de_cnt, 640);
        check("line_de_max", de_max, 639);
        check("line_sol_cnt", sol_cnt, 1);
        check("line_sof_cnt", sof_cnt, 0);
        check("line_end_x", a_x, 2);
        check("line_end_y", a_y, 1);

        // Half-rate line: CE 1,0,1,0,...
        hs_cnt = 0; sol_cnt = 0; sof_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            x_prev = a_x;
            c = (i % 2 == 0);
            step(1'b0, c);
            x_exp = c ? ((x_prev + 1) % 800) : x_prev;
            check("half_x_step", a_x, x_exp);
            if (a_hs == 1'b0) hs_cnt++;
            if (a_sol) sol_cnt++;
            if (a_sof) sof_cnt++;
        end
        check("half_hs_clk", hs_cnt, 192);
        check("half_sol_clk", sol_cnt, 1);
        check("half_sof_clk", sof_cnt, 0);
        check("half_end_y", a_y, 2);

        // Small raster: reset and first CE.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("b_rst_x", b_x, 15);
        check("b_rst_y", b_y, 9);
        check("b_rst_hs", b_hs, 0);
        check("b_rst_vs", b_vs, 0);
        check("b_rst_de", b_de, 0);
        check("b_rst_frame", b_frame, FR_RST);
        step(1'b0, 1'b1);
        check("b_first_x", b_x, 0);
        check("b_first_sof", b_sof, 1);
        check("b_first_sol", b_sol, 1);
        check("b_first_de", b_de, 1);

        // One full frame at full rate.
        hs_cnt = 0; vs_cnt = 0; de_cnt = 0; de_late = 0; sol_cnt = 0; sof_cnt = 0;
        hs_min = 1023; hs_max = 0; vs_min = 1023; vs_max = 0;
        for (int i = 0; i < 160; i++) begin
            step(1'b0, 1'b1);
            if (b_hs) begin
                hs_cnt++;
                if (b_x < hs_min) hs_min = b_x;
                if (b_x > hs_max) hs_max = b_x;
            end
            if (b_vs) begin
                vs_cnt++;
                if (b_y < vs_min) vs_min = b_y;
                if (b_y > vs_max) vs_max = b_y;
            end
            if (b_de) begin
                de_cnt++;
                if (b_y >= 6) de_late++;
            end
            if (b_sol) sol_cnt++;
            if (b_sof) sof_cnt++;
        end
        check("frame_hs_cnt", hs_cnt, 30);
        check("frame_hs_min", hs_min, 10);
        check("frame_hs_max", hs_max, 12);
        check("frame_vs_cnt", vs_cnt, 32);
        check("frame_vs_min", vs_min, 7);
        check("frame_vs_max", vs_max, 8);
        check("frame_de_cnt", de_cnt, 48);
        check("frame_de_late", de_late, 0);
        check("frame_sol_cnt", sol_cnt, 10);
        check("frame_sof_cnt", sof_cnt, 1);

        // Mid-frame reset at X=5, Y=3.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (b_x == 5 && b_y == 3) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b1);
        end
        check("mid_reach", found, 1);
        step(1'b1, 1'b1);
        check("mid_rst_x", b_x, 15);
        check("mid_rst_y", b_y, 9);
        check("mid_rst_sol", b_sol, 0);
        check("mid_rst_sof", b_sof, 0);
        step(1'b0, 1'b0);
        check("mid_hold_x", b_x, 15);
        check("mid_hold_y", b_y, 9);
        step(1'b0, 1'b1);
        check("mid_rel_x", b_x, 0);
        check("mid_rel_y", b_y, 0);
        check("mid_rel_sof", b_sof, 1);
        check("mid_rel_frame", b_frame, 0);

        // 256 further frames: FRAME follows 1..255,0 when counting, else stays 0.
        k = 0;
        for (int i = 0; i < 256 * 160; i++) begin
            step(1'b0, 1'b1);
            if (b_sof) begin
                k++;
                check("frame_seq", b_frame, FR_CNT ? (k % 256) : 0);
            end
        end
        check("frame_sof_total", k, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HS active level
- VS_POL, 0, VS active level
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- CLK, in, 1, system clock; the only clock
- RST, in, 1, reset, synchronous to CLK, active-high
- CE, in, 1, pixel-rate enable; counters advance only on CLK edges with CE=1
- X, out, 10, current horizontal count
- Y, out, 10, current vertical count
- HS, out, 1, horizontal sync at HS_POL level while asserted
- VS, out, 1, vertical sync at VS_POL level while asserted
- DE, out, 1, 1 when X<H_ACTIVE and Y<V_ACTIVE
- SOL, out, 1, start-of-line pulse
- SOF, out, 1, start-of-frame pulse
- FRAME, out, 8, frame number
REQ-003 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default); both totals SHALL be ≤1024.

Function
REQ-004 SHALL keep horizontal counter h in 0..H_TOTAL-1; on a CE edge h becomes h+1, or 0 when h=H_TOTAL-1.
REQ-005 SHALL keep vertical counter v in 0..V_TOTAL-1; v changes only on a CE edge where h wraps, becoming v+1, or 0 when v=V_TOTAL-1.
REQ-006 SHALL drive X=h and Y=v directly from registers, with no combinational path from CE to any output.
REQ-007 SHALL register HS, VS, DE, SOL and SOF so that each is consistent with the X/Y values it is presented with; there is no skew between X/Y and the flags.
REQ-008 SHALL assert HS for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 by default) and VS for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 by default).
REQ-009 SHALL assert SOL for exactly one CLK cycle, following the CE edge that sets h to 0; SOL is 0 on the next CLK cycle even if CE=0.
REQ-010 SHALL assert SOF for exactly one CLK cycle, following the CE edge that sets (h,v) to (0,0); SOL is also 1 in that cycle.
REQ-011 SHALL hold all outputs unchanged on CLK edges with CE=0, except that SOL and SOF clear.
REQ-012 SHALL accept CE held at 1 continuously, advancing one pixel per CLK.
REQ-013 SHALL let downstream delay stages align HS/VS/DE to pipelined pixel data; the block itself adds no latency beyond REQ-007.

Reset
REQ-014 SHALL, on a CLK edge with RST=1, set h=H_TOTAL-1 and v=V_TOTAL-1, and ignore CE.
REQ-015 SHALL give these outputs while RST=1 and until the first CE edge after release: X=799, Y=524 (defaults), HS and VS inactive, DE=0, SOL=0, SOF=0.
REQ-016 SHALL advance to (0,0) on the first CE edge after reset, with SOF=SOL=DE=1 in the following cycle.
REQ-017 SHALL let RST asserted mid-frame override all state on that same edge, with no partial line or frame completed.

Configuration
REQ-018 SHALL, when macro VGA_TIMING_FRAME_CNT_EN is defined, implement FRAME as an 8-bit counter that resets to 255 and increments (wrapping 255→0) on the same edge that sets SOF, so that the first frame after reset reads 0.
REQ-019 SHALL, when VGA_TIMING_FRAME_CNT_EN is undefined, tie FRAME to constant 0 with no flops; all other behaviour is identical.

Verification
REQ-020 SHALL cover: RST held 3 cycles with CE=1 → X=799, Y=524, HS/VS inactive, DE=0; release, first CE → X=0, Y=0, SOF=SOL=DE=1 for one cycle.
REQ-021 SHALL cover: CE=1 continuously for one line → HS active-low exactly for X=656..751 (96 cycles); DE=1 exactly for X=0..639; SOL once per 800 cycles.
REQ-022 SHALL cover: CE=1 continuously for a full frame → VS low exactly for Y=490..491 (1600 CE cycles); SOF once per 420000 CE cycles; DE=0 for Y≥480.
REQ-023 SHALL cover: CE pattern 1,0 (half rate) → one X step per 2 CLK; SOF/SOL each high for 1 CLK only; HS width 192 CLK.
REQ-024 SHALL cover: RST pulsed at X=300, Y=200 → next cycle X=799, Y=524; first CE after release → SOF.
REQ-025 SHALL cover: with VGA_TIMING_FRAME_CNT_EN defined, 257 frames → FRAME sequence 0,1,…,255,0; with it undefined → FRAME=0 throughout.
